// File: rtl/simon_pkg.sv
// simon_pkg
// Shared definitions for the Simon game blocks (collect_state, check_state
// and the display block).
//   colour_t          : 2-bit colour codes, RED=0 GREEN=1 BLUE=2 YELLOW=3
//   collect_state_t   : state encoding of the press-collection FSM
//   *_DEFAULT         : default debounce and press-window lengths in cycles
//   is_one_hot        : true when exactly one of four buttons is pressed
//   btn_to_colour     : maps a one-hot button vector to its colour code
package simon_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        BLUE   = 2'd2,
        YELLOW = 2'd3
    } colour_t;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        ARM          = 2'd1,
        WAIT_PRESS   = 2'd2,
        WAIT_RELEASE = 2'd3
    } collect_state_t;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 16;
    localparam int TIMEOUT_CYCLES_DEFAULT  = 10_000_000;

    // v & (v-1) clears the lowest set bit, so it is zero only for a
    // single set bit (or for zero, which is excluded separately).
    function automatic logic is_one_hot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Only meaningful for a one-hot input; anything else maps to RED.
    function automatic colour_t btn_to_colour(input logic [3:0] v);
        colour_t c;
        case (v)
            4'b0010: c = GREEN;
            4'b0100: c = BLUE;
            4'b1000: c = YELLOW;
            default: c = RED;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// btn_sync
// Two-flop synchronizer bringing the four asynchronous colour buttons into
// the clk domain.
//   clk   : system clock
//   rst   : synchronous active-high reset, clears both flop stages
//   btn   : raw buttons, asynchronous to clk
//   btn_s : synchronized buttons, two cycles behind btn
module btn_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    output logic [3:0] btn_s
);

    logic [3:0] meta;

    // First stage may go metastable; only the second stage is used downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta  <= 4'd0;
            btn_s <= 4'd0;
        end else begin
            meta  <= btn;
            btn_s <= meta;
        end
    end

endmodule

// File: rtl/collect_state.sv
// collect_state
// Captures the player's sequence of N+1 colour presses for the current round.
//   clk           : system clock, rising edge
//   rst_collect   : synchronous active-high reset
//   en_collect    : starts a capture when idle
//   btn[3:0]      : raw colour buttons, btn[k] is colour code k
//   round_ctr_in  : current round N; N+1 presses are collected
//   seq_in_check  : captured codes, press i in bits [2i+1:2i]
//   en_check      : one-cycle pulse, sequence complete and final
//   colour_valid  : one-cycle pulse per accepted press
//   colour_out    : code of the last accepted press
//   press_ctr     : presses accepted in this capture (0..16)
//   timeout       : one-cycle pulse when the press window expires
//   busy          : high whenever the FSM is not idle
module collect_state
    import simon_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_collect,
    input  logic        en_collect,
    input  logic [3:0]  btn,
    input  logic [3:0]  round_ctr_in,
    output logic [31:0] seq_in_check,
    output logic        en_check,
    output logic        colour_valid,
    output logic [1:0]  colour_out,
    output logic [4:0]  press_ctr,
    output logic        timeout,
    output logic        busy
);

    // Counters only need to reach their terminal value (length - 1).
    localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    collect_state_t   state;
    logic [3:0]       btn_s;
    logic [3:0]       n_reg;
    logic [DEB_W-1:0] deb_cnt;
    logic [TMO_W-1:0] tmo_cnt;

    logic       press_hit;
    colour_t    press_code;
    logic       last_press;
    logic [3:0] slot;
    logic [4:0] press_ctr_inc;

    btn_sync u_btn_sync (
        .clk   (clk),
        .rst   (rst_collect),
        .btn   (btn),
        .btn_s (btn_s)
    );

    // Press decode. last_press compares the count before this press with N,
    // i.e. this press brings the count to N+1. The increment saturates at 16
    // so the counter can never wrap even if N were reached some other way.
    always_comb begin
        press_hit     = is_one_hot(btn_s);
        press_code    = btn_to_colour(btn_s);
        last_press    = (press_ctr == {1'b0, n_reg});
        slot          = press_ctr[3:0];
        press_ctr_inc = (press_ctr == 5'd16) ? press_ctr : press_ctr + 5'd1;
    end

    // Single registered FSM. Pulse outputs default low every cycle and are
    // raised only on the edge that causes them. A press is tested before the
    // timer so that a final press on the expiry edge wins over the timeout.
    always_ff @(posedge clk) begin
        if (rst_collect) begin
            state        <= IDLE;
            seq_in_check <= 32'd0;
            press_ctr    <= 5'd0;
            colour_out   <= 2'd0;
            en_check     <= 1'b0;
            colour_valid <= 1'b0;
            timeout      <= 1'b0;
            busy         <= 1'b0;
            deb_cnt      <= '0;
            tmo_cnt      <= '0;
            n_reg        <= 4'd0;
        end else begin
            en_check     <= 1'b0;
            colour_valid <= 1'b0;
            timeout      <= 1'b0;

            case (state)
                IDLE: begin
                    if (en_collect) begin
                        state        <= ARM;
                        busy         <= 1'b1;
                        seq_in_check <= 32'd0;
                        press_ctr    <= 5'd0;
                        n_reg        <= round_ctr_in;
                        deb_cnt      <= '0;
                    end
                end

                // A button held when the capture starts keeps resetting the
                // debounce count, so it can never be taken as a press.
                ARM, WAIT_RELEASE: begin
                    if (btn_s != 4'd0) begin
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        deb_cnt <= '0;
                        tmo_cnt <= '0;
                        state   <= WAIT_PRESS;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_W'(1);
                    end
                end

                WAIT_PRESS: begin
                    if (press_hit) begin
                        seq_in_check[{slot, 1'b0} +: 2] <= press_code;
                        press_ctr    <= press_ctr_inc;
                        colour_out   <= press_code;
                        colour_valid <= 1'b1;
                        deb_cnt      <= '0;
                        if (last_press) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            en_check <= 1'b1;
                        end else begin
                            state <= WAIT_RELEASE;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_collect_state.sv
// tb_collect_state
// Directed self-checking bench for collect_state with DEBOUNCE_CYCLES=4 and
// TIMEOUT_CYCLES=100. Pulse outputs are tallied by a monitor on the falling
// edge; tests compare the change in those tallies against expectations.
module tb_collect_state;

    logic        clk;
    logic        rst_collect;
    logic        en_collect;
    logic [3:0]  btn;
    logic [3:0]  round_ctr_in;
    logic [31:0] seq_in_check;
    logic        en_check;
    logic        colour_valid;
    logic [1:0]  colour_out;
    logic [4:0]  press_ctr;
    logic        timeout;
    logic        busy;

    int checks_total  = 0;
    int checks_passed = 0;

    int en_cnt    = 0;
    int valid_cnt = 0;
    int tmo_cnt   = 0;
    int both_cnt  = 0;

    collect_state #(
        .DEBOUNCE_CYCLES (4),
        .TIMEOUT_CYCLES  (100)
    ) dut (
        .clk          (clk),
        .rst_collect  (rst_collect),
        .en_collect   (en_collect),
        .btn          (btn),
        .round_ctr_in (round_ctr_in),
        .seq_in_check (seq_in_check),
        .en_check     (en_check),
        .colour_valid (colour_valid),
        .colour_out   (colour_out),
        .press_ctr    (press_ctr),
        .timeout      (timeout),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse tally, sampled mid-cycle.
    always @(negedge clk) begin
        if (en_check)             en_cnt    <= en_cnt + 1;
        if (colour_valid)         valid_cnt <= valid_cnt + 1;
        if (timeout)              tmo_cnt   <= tmo_cnt + 1;
        if (en_check && timeout)  both_cnt  <= both_cnt + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic startCapture(input logic [3:0] n);
        round_ctr_in = n;
        en_collect   = 1'b1;
        tick(1);
        en_collect   = 1'b0;
    endtask

    // Press a button, wait (bounded) for the colour_valid pulse, release and
    // allow the release debounce to finish. Reports en_check as seen together
    // with colour_valid.
    task automatic applyStimulus(input logic [3:0] pat, output logic en_with_valid);
        logic seen;
        seen          = 1'b0;
        en_with_valid = 1'b0;
        btn           = pat;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick(1);
            if (colour_valid) begin
                seen          = 1'b1;
                en_with_valid = en_check;
            end
        end
        checkOutput("press_accepted", {31'd0, seen}, 32'd1);
        btn = 4'd0;
        tick(10);
    endtask

    initial begin
        logic ev;
        int   en0, val0, tmo0;

        rst_collect  = 1'b1;
        en_collect   = 1'b0;
        btn          = 4'd0;
        round_ctr_in = 4'd0;
        tick(3);

        $display("[TB] reset state");
        checkOutput("rst_seq",    seq_in_check, 32'd0);
        checkOutput("rst_ctr",    {27'd0, press_ctr}, 32'd0);
        checkOutput("rst_busy",   {31'd0, busy}, 32'd0);
        checkOutput("rst_pulses", {29'd0, en_check, colour_valid, timeout}, 32'd0);
        checkOutput("rst_colour", {30'd0, colour_out}, 32'd0);
        rst_collect = 1'b0;
        tick(2);

        $display("[TB] N=0 single press BLUE");
        en0 = en_cnt; tmo0 = tmo_cnt;
        startCapture(4'd0);
        checkOutput("n0_busy", {31'd0, busy}, 32'd1);
        tick(6);
        applyStimulus(4'b0100, ev);
        checkOutput("n0_en_with_valid", {31'd0, ev}, 32'd1);
        checkOutput("n0_seq",    seq_in_check, 32'h0000_0002);
        checkOutput("n0_ctr",    {27'd0, press_ctr}, 32'd1);
        checkOutput("n0_colour", {30'd0, colour_out}, 32'd2);
        checkOutput("n0_en_cnt", en_cnt - en0, 32'd1);
        checkOutput("n0_tmo",    tmo_cnt - tmo0, 32'd0);
        checkOutput("n0_idle",   {31'd0, busy}, 32'd0);

        $display("[TB] N=2 presses RED YELLOW GREEN");
        en0 = en_cnt;
        startCapture(4'd2);
        tick(6);
        applyStimulus(4'b0001, ev);
        checkOutput("n2_en_p1", {31'd0, ev}, 32'd0);
        applyStimulus(4'b1000, ev);
        checkOutput("n2_en_p2", {31'd0, ev}, 32'd0);
        applyStimulus(4'b0010, ev);
        checkOutput("n2_en_p3", {31'd0, ev}, 32'd1);
        checkOutput("n2_seq",    seq_in_check, 32'h0000_001C);
        checkOutput("n2_en_cnt", en_cnt - en0, 32'd1);
        tick(5);
        checkOutput("n2_seq_hold", seq_in_check, 32'h0000_001C);

        $display("[TB] N=15 sixteen YELLOW presses");
        en0 = en_cnt; val0 = valid_cnt;
        startCapture(4'd15);
        tick(6);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(4'b1000, ev);
            checkOutput("n15_en_step", {31'd0, ev}, (i == 15) ? 32'd1 : 32'd0);
        end
        checkOutput("n15_seq",    seq_in_check, 32'hFFFF_FFFF);
        checkOutput("n15_ctr",    {27'd0, press_ctr}, 32'd16);
        checkOutput("n15_valids", valid_cnt - val0, 32'd16);
        checkOutput("n15_en_cnt", en_cnt - en0, 32'd1);

        $display("[TB] two buttons then RED");
        val0 = valid_cnt;
        startCapture(4'd0);
        tick(6);
        btn = 4'b0011;
        tick(10);
        checkOutput("multi_no_valid", valid_cnt - val0, 32'd0);
        checkOutput("multi_ctr",      {27'd0, press_ctr}, 32'd0);
        applyStimulus(4'b0001, ev);
        checkOutput("multi_ctr_after", {27'd0, press_ctr}, 32'd1);
        checkOutput("multi_seq",       seq_in_check, 32'd0);
        checkOutput("multi_valids",    valid_cnt - val0, 32'd1);

        $display("[TB] button held through start");
        val0 = valid_cnt;
        btn = 4'b0100;
        tick(4);
        startCapture(4'd1);
        tick(12);
        checkOutput("held_no_valid", valid_cnt - val0, 32'd0);
        btn = 4'd0;
        tick(10);
        applyStimulus(4'b0100, ev);
        checkOutput("held_ctr",    {27'd0, press_ctr}, 32'd1);
        checkOutput("held_valids", valid_cnt - val0, 32'd1);
        checkOutput("held_busy",   {31'd0, busy}, 32'd1);

        $display("[TB] reset mid-capture");
        rst_collect = 1'b1;
        tick(1);
        rst_collect = 1'b0;
        en0 = en_cnt;
        startCapture(4'd3);
        tick(6);
        applyStimulus(4'b1000, ev);
        checkOutput("mid_seq_pre", seq_in_check, 32'd3);
        round_ctr_in = 4'd0;
        en_collect   = 1'b1;
        tick(1);
        en_collect   = 1'b0;
        checkOutput("ignore_en_ctr", {27'd0, press_ctr}, 32'd1);
        checkOutput("ignore_en_seq", seq_in_check, 32'd3);
        rst_collect = 1'b1;
        tick(1);
        checkOutput("mid_rst_seq",    seq_in_check, 32'd0);
        checkOutput("mid_rst_ctr",    {27'd0, press_ctr}, 32'd0);
        checkOutput("mid_rst_colour", {30'd0, colour_out}, 32'd0);
        checkOutput("mid_rst_busy",   {31'd0, busy}, 32'd0);
        rst_collect = 1'b0;
        tick(5);
        checkOutput("mid_rst_no_en", en_cnt - en0, 32'd0);

        $display("[TB] timeout with no press");
        en0 = en_cnt; tmo0 = tmo_cnt;
        startCapture(4'd0);
        tick(103);
        checkOutput("tmo_early", {31'd0, timeout}, 32'd0);
        checkOutput("tmo_busy",  {31'd0, busy}, 32'd1);
        tick(1);
        checkOutput("tmo_pulse", {31'd0, timeout}, 32'd1);
        checkOutput("tmo_idle",  {31'd0, busy}, 32'd0);
        checkOutput("tmo_no_en", {31'd0, en_check}, 32'd0);
        tick(1);
        checkOutput("tmo_one_cycle", {31'd0, timeout}, 32'd0);
        checkOutput("tmo_cnt",       tmo_cnt - tmo0, 32'd1);
        checkOutput("tmo_en_cnt",    en_cnt - en0, 32'd0);
        checkOutput("never_both",    both_cnt, 32'd0);

        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/collect_state.md
COLLECT_STATE -- requirements
Module: collect_state

Interface
REQ-001 SHALL provide parameter DEBOUNCE_CYCLES, default 16, the number of consecutive all-released cycles required before a new press is accepted.
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, default 10_000_000, the maximum number of idle cycles allowed while waiting for a press.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_collect, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port en_collect, input, 1 bit: starts a capture when the block is in IDLE.
REQ-006 SHALL have port btn, input, 4 bits: raw colour buttons, asynchronous to clk; btn[k] maps to colour code k.
REQ-007 SHALL have port round_ctr_in, input, 4 bits: the current round N; N+1 presses are expected.
REQ-008 SHALL have port seq_in_check, output, 32 bits: the captured sequence; colour i occupies bits [2i+1:2i], LSB-first.
REQ-009 SHALL have port en_check, output, 1 bit: one-cycle pulse meaning the sequence is complete.
REQ-010 SHALL have port colour_valid, output, 1 bit: one-cycle pulse per accepted press.
REQ-011 SHALL have port colour_out, output, 2 bits: the code of the last accepted press.
REQ-012 SHALL have port press_ctr, output, 5 bits: the number of presses accepted in the current capture.
REQ-013 SHALL have port timeout, output, 1 bit: one-cycle pulse when the press window expires.
REQ-014 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 SHALL pass btn through a 2-flop synchronizer; the synchronized value is btn_s, and all press logic uses btn_s only.
REQ-016 SHALL implement the FSM states IDLE, ARM, WAIT_PRESS and WAIT_RELEASE.
REQ-017 SHALL leave IDLE for ARM on en_collect=1, and on that edge clear seq_in_check and press_ctr and latch N from round_ctr_in.
REQ-018 SHALL ignore en_collect while busy=1.
REQ-019 ARM: SHALL move to WAIT_PRESS after btn_s==0 for DEBOUNCE_CYCLES consecutive cycles; any nonzero btn_s restarts the count, so a button held at start is never counted.
REQ-020 WAIT_PRESS: SHALL accept a press when btn_s is exactly one-hot: write code k to bits [2*press_ctr+1:2*press_ctr], increment press_ctr, set colour_out=k, pulse colour_valid next cycle, then go to WAIT_RELEASE.
REQ-021 WAIT_PRESS: SHALL treat a non-one-hot nonzero btn_s (two or more buttons) as no press; nothing is recorded and the timer keeps running.
REQ-022 WAIT_RELEASE: SHALL return to WAIT_PRESS after btn_s==0 for DEBOUNCE_CYCLES consecutive cycles.
REQ-023 SHALL, when the accepted press makes press_ctr equal N+1, go to IDLE instead of WAIT_RELEASE and assert en_check for exactly the next cycle, with seq_in_check already final in that cycle.
REQ-024 SHALL keep seq_in_check stable from the en_check pulse until the next en_collect or reset.
REQ-025 SHALL leave bits above 2*(N+1)-1 at zero.
REQ-026 For N=15, SHALL accept 16 presses, fill all 32 bits, and saturate press_ctr at 16 (never wrap).
REQ-027 SHALL use a timeout timer that is cleared on entering WAIT_PRESS and counts only in WAIT_PRESS.
REQ-028 On reaching TIMEOUT_CYCLES, SHALL pulse timeout for one cycle, go to IDLE, and not assert en_check; seq_in_check holds the partial capture.
REQ-029 If the final press and the timeout expiry occur on the same edge, SHALL let the press win: en_check pulses and timeout does not.
REQ-030 SHALL never assert en_check and timeout in the same cycle.
REQ-031 SHALL register all outputs.

Reset
REQ-032 On rst_collect=1 at a clock edge, SHALL set state=IDLE and clear seq_in_check, press_ctr, colour_out, en_check, colour_valid, timeout, busy, the debounce and timeout counters, and the synchronizer flops to 0.
REQ-033 SHALL give rst_collect priority over en_collect and over any press, including mid-capture; a reset mid-capture produces no en_check.

Structure
REQ-034 SHALL take from shared package simon_pkg: the 2-bit colour codes (RED=0, GREEN=1, BLUE=2, YELLOW=3), the collect-state enum, and the default DEBOUNCE/TIMEOUT constants; check_state and the display block use the same package.
REQ-035 SHALL place the 4-bit 2-flop synchronizer in a sub-module named btn_sync; the FSM, counters and capture register stay in collect_state.

Verification
REQ-036 SHALL cover: N=0, DEBOUNCE=4; press btn=0100 -> seq_in_check=0x00000002, press_ctr=1, en_check one cycle, timeout=0.
REQ-037 SHALL cover: N=2; presses 0001,1000,0010, each with release -> seq=0x0000001C, exactly one en_check, after the third colour_valid.
REQ-038 SHALL cover: N=15; 16 presses of 1000 -> seq=0xFFFFFFFF, press_ctr=16, no wrap.
REQ-039 SHALL cover: btn=0011 in WAIT_PRESS, then 0001 -> only code 0 is recorded, press_ctr=1.
REQ-040 SHALL cover: button held through en_collect, then released and pressed again -> one press recorded, not two.
REQ-041 SHALL cover: TIMEOUT=100 with no press -> timeout pulses at cycle 100 of WAIT_PRESS, en_check=0, busy drops; rst_collect pulsed mid-capture -> all outputs return to 0 on the next edge.
